// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of fetched entries; push and pop together are accepted when full.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fq_entry_t              wr_data,
  output fq_entry_t              rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, in-order imem requests, response queue, redirect flush.
// Build option FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [11:0] RESET_PC        = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [11:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [11:0] if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [PC_W-1:0] last_pc;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   inflight_nxt;
  logic [IW-1:0]   drop;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  fq_entry_t       head;
  fq_entry_t       rsp_entry;
  logic            issue;
  logic            rsp_fire;
  logic            rsp_keep;
  logic            bypass;
  logic            push;
  logic            pop;

  // Queue slots are reserved at issue time, so a returning word always has room.
  assign imem_req_valid = !reset && !redirect_valid && !full
                          && (inflight < IW'(MAX_OUTSTANDING))
                          && ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;

  assign rsp_fire  = imem_rsp_valid && (inflight != '0);
  assign rsp_keep  = rsp_fire && (drop == '0) && !redirect_valid;
  assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && empty;
`else
  assign bypass = 1'b0;
`endif

  assign push         = rsp_keep && !(bypass && !stall);
  assign pop          = !empty && !stall && !redirect_valid;
  assign inflight_nxt = inflight + IW'(issue) - IW'(rsp_fire);
  assign if_valid     = !empty || bypass;

  always_comb begin
    if_instr = NOP_INSTR;
    if_pc    = last_pc;
    if (!empty) begin
      if_instr = head.instr;
      if_pc    = head.pc;
    end else if (bypass) begin
      if_instr = imem_rsp_data;
      if_pc    = rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      last_pc  <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (if_valid) last_pc <= if_pc;
      // Every request still outstanding after this cycle belongs to the wrong path.
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop     <= inflight_nxt;
      end else begin
        if (issue)                   fetch_pc <= fetch_pc + 12'd4;
        if (rsp_keep)                rsp_pc   <= rsp_pc + 12'd4;
        if (rsp_fire && drop != '0)  drop     <= drop - 1'b1;
      end
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (redirect_valid),
    .wr_data (rsp_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [11:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [11:0] if_pc;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: each accepted request answers lat cycles later, one word per cycle, in order.
  typedef struct {
    int          due;
    logic [11:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [11:0] req_log[$];
  logic [11:0] pop_log[$];
  int          cyc = 0;
  int          lat = 1;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    if (reset) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {20'hBEEF0, pend[0].addr};
      void'(pend.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && imem_req_valid && imem_req_ready) begin
      pend.push_back('{due: cyc + lat, addr: imem_req_addr});
      req_log.push_back(imem_req_addr);
    end
    if (!reset && if_valid && !stall && !redirect_valid) begin
      pop_log.push_back(if_pc);
      check_val("pop_instr", if_instr, {20'hBEEF0, if_pc});
    end
  end

  function automatic logic [31:0] pop_at(input int i);
    if (i < pop_log.size()) return {20'h0, pop_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return {20'h0, req_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input bit use_pops, input logic [11:0] base, input int n);
    logic [11:0] exp_pc;
    exp_pc = base;
    for (int i = 0; i < n; i++) begin
      check_val(tag, use_pops ? pop_at(i) : req_at(i), {20'h0, exp_pc});
      exp_pc = exp_pc + 12'd4;
    end
  endtask

  // Leaves the caller at the start of cycle 0, the first cycle out of reset.
  task automatic do_reset(input int latency);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    lat            = latency;
    repeat (3) next_cycle();
    at_neg();
    check_val("rst_if_valid", if_valid, 1'b0);
    check_val("rst_if_instr", if_instr, NOP_INSTR);
    check_val("rst_if_pc", if_pc, 12'h000);
    check_val("rst_req_valid", imem_req_valid, 1'b0);
    next_cycle();
    reset = 1'b0;
    pop_log.delete();
    req_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with single-cycle memory
    do_reset(1);
    at_neg();
    check_val("a_req_valid", imem_req_valid, 1'b1);
    check_val("a_req_addr", imem_req_addr, 12'h000);
    next_cycle();
    at_neg();
    check_val("a_first_valid", if_valid, BYP);
    check_val("a_first_instr", if_instr, BYP ? 32'hBEEF0000 : NOP_INSTR);
    for (int c = 2; c < 12; c++) begin
      next_cycle();
      at_neg();
      check_val("a_steady_valid", if_valid, 1'b1);
      check_val("a_steady_pc", if_pc, BYP ? 4 * (c - 1) : 4 * (c - 2));
    end
    check_seq("a_pop_seq", 1'b1, 12'h000, 8);
    check_seq("a_req_seq", 1'b0, 12'h000, 8);

    // Stall fills the queue, release drains it in order
    do_reset(1);
    stall = 1'b1;
    repeat (9) begin
      at_neg();
      next_cycle();
    end
    at_neg();
    check_val("b_full_req_valid", imem_req_valid, 1'b0);
    check_val("b_full_if_valid", if_valid, 1'b1);
    check_val("b_full_if_pc", if_pc, 12'h000);
    next_cycle();
    stall = 1'b0;
    repeat (12) next_cycle();
    check_seq("b_pop_seq", 1'b1, 12'h000, 8);

    // Redirect with two requests in flight
    do_reset(3);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    at_neg();
    check_val("c_redir_req_valid", imem_req_valid, 1'b0);
    check_val("c_redir_if_valid", if_valid, 1'b0);
    next_cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    req_log.delete();
    repeat (15) next_cycle();
    check_seq("c_req_seq", 1'b0, 12'h100, 3);
    check_seq("c_pop_seq", 1'b1, 12'h100, 3);

    // Redirect colliding with a response and a pop, queue holding three words
    do_reset(1);
    stall = 1'b1;
    repeat (4) next_cycle();
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h206;
    at_neg();
    check_val("d_redir_req_valid", imem_req_valid, 1'b0);
    check_val("d_redir_if_valid", if_valid, 1'b1);
    check_val("d_redir_if_pc", if_pc, 12'h000);
    next_cycle();
    redirect_valid = 1'b0;
    at_neg();
    check_val("d_after_if_valid", if_valid, 1'b0);
    check_val("d_after_if_instr", if_instr, NOP_INSTR);
    check_val("d_after_if_pc", if_pc, 12'h000);
    check_val("d_after_req_valid", imem_req_valid, 1'b1);
    check_val("d_after_req_addr", imem_req_addr, 12'h204);
    repeat (8) next_cycle();
    check_seq("d_pop_seq", 1'b1, 12'h204, 3);

    // PC wrap at the top of the 4 KiB space
    do_reset(1);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFF9;
    next_cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    req_log.delete();
    repeat (10) next_cycle();
    check_seq("e_req_seq", 1'b0, 12'hFF8, 3);
    check_seq("e_pop_seq", 1'b1, 12'hFF8, 4);

    // Reset while streaming
    do_reset(1);
    at_neg();
    check_val("f_req_addr", imem_req_addr, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
